// File: rtl/fpu_mul_arbiter.sv
// Purpose : two-requester arbiter in front of one shared combinational FP32 multiplier.
// Latency : response valid SETTLE_CYCLES+1 cycles after acceptance; one op in flight.
// Backpressure: an owner holding respN_ready low stalls the arbiter in RESP; requests wait in IDLE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready/a/b       request handshake and operands (N = 0, 1)
//   respN_valid/ready          response handshake per requester
//   resp_result, resp_nan      shared registered product and its NaN flag
//   mul_a, mul_b, mul_c        registered operands to, and product from, the multiplier
//   busy, grant_id             not-IDLE indication and owner of the op in flight
module fpu_mul_arbiter #(
  // WAIT cycles given to the external multiplier; legal range 1..15
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_nan,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_c,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic [3:0]  cnt;
  logic        gnt;
  logic        accept;
  logic        capture;

  // Round-robin only matters on contention: the requester not served last wins.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = ~last_grant;
    else if (req1_valid)          gnt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~gnt;
          req1_ready = gnt;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        // Last settle cycle: product is stable, register it this edge.
        if (cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Only the owner's ready completes the handshake.
        if (grant_id ? resp1_ready : resp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign resp0_valid = (state == RESP) && !grant_id;
  assign resp1_valid = (state == RESP) &&  grant_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a       <= 32'h0;
      mul_b       <= 32'h0;
      resp_result <= 32'h0;
      resp_nan    <= 1'b0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;  // requester 0 wins the first contention
      cnt         <= 4'd0;
    end else begin
      if (accept) begin
        mul_a      <= gnt ? req1_a : req0_a;
        mul_b      <= gnt ? req1_b : req0_b;
        grant_id   <= gnt;
        last_grant <= gnt;
        cnt        <= 4'(SETTLE_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        resp_result <= mul_c;
        resp_nan    <= (&mul_c[30:23]) && (|mul_c[22:0]);
      end
    end
  end

endmodule

// File: doc/fpu_mul_arbiter.md
FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: number of WAIT cycles allowed for the external combinational single-precision multiplier to settle; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 IEEE-754 single-precision operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006 for requester 1.
REQ-008 resp0_valid  output  1  result for requester 0 available.
REQ-009 resp0_ready  input  1  requester 0 consumes its result.
REQ-010 resp1_valid, resp1_ready  same as REQ-008..009 for requester 1.
REQ-011 resp_result  output  32  registered product, shared by both responders.
REQ-012 resp_nan  output  1  resp_result is NaN (exponent 0xFF, mantissa nonzero).
REQ-013 mul_a, mul_b  output  32 each  registered operands driven to the shared multiplier.
REQ-014 mul_c  input  32  combinational product returned by the shared multiplier.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 grant_id  output  1  owner of the operation in flight (0 or 1).

Function
REQ-017 FSM states: IDLE, WAIT, RESP; exactly one operation is in flight at a time.
REQ-018 IDLE: grant is combinational; if only one reqN_valid is high, that requester is granted; if both are high, the requester not granted last is granted.
REQ-019 reqN_ready is high only in IDLE and only for the granted requester; it is never high for both requesters in the same cycle.
REQ-020 Acceptance (reqN_valid & reqN_ready) latches reqN_a/reqN_b into mul_a/mul_b, latches grant_id, loads the settle counter with SETTLE_CYCLES, updates the last-grant pointer, and moves the FSM to WAIT.
REQ-021 WAIT: the counter decrements once per cycle; on the cycle the counter reaches 1, mul_c is registered into resp_result, resp_nan is computed from mul_c, and the FSM moves to RESP.
REQ-022 Latency: for acceptance in cycle T, resp{grant_id}_valid is first high in cycle T+1+SETTLE_CYCLES.
REQ-023 RESP: only resp{grant_id}_valid is high; it holds, with resp_result and resp_nan stable, until the matching respN_ready is sampled high.
REQ-024 The RESP handshake returns the FSM to IDLE; a new acceptance is possible no earlier than the following cycle (maximum throughput is 1 op per SETTLE_CYCLES+2 cycles).
REQ-025 respN_ready from the non-owning requester is ignored; reqN_valid is ignored outside IDLE.
REQ-026 mul_a/mul_b hold their values from acceptance until the next acceptance; they do not change in WAIT or RESP.
REQ-027 No arithmetic, rounding or special-case handling is done here: resp_result equals mul_c bit-for-bit.

Reset
REQ-028 While rst_n is low at a clock edge: FSM to IDLE; mul_a, mul_b and resp_result to 0x00000000; resp_nan, resp0_valid, resp1_valid, busy and grant_id to 0; last-grant pointer to 1, so requester 0 wins the first contention; settle counter to 0.
REQ-029 A reset during WAIT or RESP abandons the in-flight operation; no response is issued for it afterwards.

Verification
REQ-030 SETTLE_CYCLES=1. req0: 0x40000000 * 0x40400000 (2.0*3.0), accepted in cycle T, resp0_ready=1 -> resp0_valid high in cycle T+2 only, resp_result=0x40C00000, resp_nan=0, resp1_valid=0.
REQ-031 Out of reset, req0 and req1 valid in the same cycle -> req0 granted first (grant_id=0); req1 granted at the next IDLE; a third simultaneous request goes to req0 (alternation).
REQ-032 resp0_ready held low for 5 cycles in RESP -> resp0_valid, resp_result and mul_a/mul_b stable; req1_ready=0 throughout; IDLE is re-entered one cycle after resp0_ready rises.
REQ-033 req1: 0x7FC00000 * 0x3F800000 with the multiplier returning 0x7FC00000 -> resp1_valid=1, resp_nan=1; 0x7F800000 (Inf) returned -> resp_nan=0.
REQ-034 rst_n low for 1 cycle mid-WAIT -> next cycle busy=0, both respN_valid=0, mul_a=mul_b=0, and no response ever appears for the abandoned operation.
REQ-035 SETTLE_CYCLES=4, mul_c changed during WAIT -> resp_result equals the mul_c value sampled in the 4th WAIT cycle; resp0_valid is first high 5 cycles after acceptance.
